ctr_sequencer: RTL and testbench
================================

// Module: ctr_sequencer
// PURPOSE
//  Controller for the NPU 16-bit down-counter datapath: captures reload value byte-wise
//  ({DB,DD}), sequences load/run/terminate, supports one-shot and auto-reload modes.
//  Raises a 1-cycle terminal pulse (CTR_OUT) plus sticky IRQ for the layer/inference FSM.
//  Sits between host/layer-FSM control strobes and the counting datapath (held internally).
// PARAMETERS
//  PRESC_W     4         width of prescaler divide value (used only with PRESCALE_EN)
//  RELOAD_RST  16'hFFFF  reset value of reload register
// PORTS
//  CLKEXT   in   1   single clock, all state updates on rising edge
//  RST_N    in   1   asynchronous, active-low reset
//  DB       in   8   reload high byte data
//  DD       in   8   reload low byte data
//  LD_HI    in   1   write DB into reload[15:8]
//  LD_LO    in   1   write DD into reload[7:0]
//  START    in   1   begin count (from IDLE or DONE)
//  STOP     in   1   abort count, go IDLE
//  MODE     in   1   0=one-shot, 1=auto-reload; latched in LOAD
//  IRQ_CLR  in   1   clear sticky IRQ
//  PRESC    in   PRESC_W  tick every PRESC+1 cycles (port exists only with PRESCALE_EN)
//  CTR_OUT  out  1   1-cycle terminal-count pulse
//  IRQ      out  1   sticky terminal flag
//  BUSY     out  1   1 in LOAD or RUN
//  CNT      out  16  current count value
//  STATE    out  2   IDLE=00 LOAD=01 RUN=10 DONE=11
// BEHAVIOUR
//  Reset: STATE=IDLE, CNT=0, reload=RELOAD_RST, mode_q=0, CTR_OUT=0, IRQ=0, BUSY=0, prescaler=0.
//  Reload writes accepted in any state; counter always consumes the pre-edge reload value.
//  IDLE: START & reload!=0 -> LOAD; START & reload==0 ignored. CNT holds.
//  LOAD (1 cycle): CNT<=reload, mode_q<=MODE, prescaler cleared -> RUN.
//  RUN: on each tick CNT<=CNT-1. Tick with CNT==1 is terminal: CTR_OUT=1 next cycle, IRQ set;
//   mode_q=0 -> CNT<=0, -> DONE; mode_q=1 -> CNT<=reload, stay RUN (period = reload ticks, no gap).
//  DONE: CNT=0 held; START -> LOAD (reload!=0 rule as IDLE).
//  STOP in any state -> IDLE next edge, CNT frozen at current value; STOP beats START same cycle.
//  CTR_OUT registered, never high two consecutive cycles unless reload==1 in auto-reload.
//  IRQ: set on terminal, cleared by IRQ_CLR; set wins over simultaneous clear.
//  RST_N low mid-RUN: immediate return to reset values, no CTR_OUT pulse.
//  Arithmetic unsigned 16-bit; CNT never wraps below 0.
// CONFIGURATION
//  NPU_CTR_PRESCALE_EN defined: PRESC port present; tick every PRESC+1 cycles in RUN,
//   prescaler restarts in LOAD and on each auto-reload.
//  Undefined: tick every cycle in RUN; PRESC port and prescaler logic absent.
// STRUCTURE
//  ctr_pkg: state typedef/encodings (IDLE/LOAD/RUN/DONE), CNT_W=16, RELOAD_RST default.
//  Sub-module ctr_prescaler (PRESC_W counter, tick output, sync clear), instantiated only
//   under NPU_CTR_PRESCALE_EN; FSM, reload register and count in ctr_sequencer.
// TESTING
//  1 Reset mid-RUN (CNT=0x1234) -> CNT=0, STATE=00, IRQ=0, CTR_OUT=0, reload=0xFFFF.
//  2 DB=00/LD_HI, DD=05/LD_LO, MODE=0, START -> CNT=5 after LOAD, CTR_OUT high 1 cycle
//    6 edges after START sampled, STATE=11, IRQ=1, CNT=0.
//  3 reload=3, MODE=1 -> CTR_OUT every 3 cycles; write reload=2 mid-period -> current period 3,
//    next 2; STOP -> STATE=00 next edge, CNT frozen.
//  4 reload=0 + START -> stays IDLE; START&STOP same cycle in DONE -> IDLE.
//  5 IRQ_CLR coincident with terminal -> IRQ=1; IRQ_CLR alone next cycle -> IRQ=0.
//  6 NPU_CTR_PRESCALE_EN, PRESC=1, reload=2, MODE=0 -> terminal 4 cycles after LOAD.

Source files
------------

// File: rtl/ctr_pkg.sv
// Shared types and constants for the NPU down-counter sequencer.
package ctr_pkg;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] RELOAD_RST_DEF = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_DONE = 2'b11
  } ctr_state_t;

endpackage

// File: rtl/ctr_prescaler.sv
// Tick divider for the counter: asserts tick every PRESC+1 enabled cycles.
// Present only when NPU_CTR_PRESCALE_EN is defined.
`ifdef NPU_CTR_PRESCALE_EN
module ctr_prescaler #(
  parameter int PRESC_W = 4
) (
  input  logic               CLKEXT,
  input  logic               RST_N,
  input  logic               clr,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] div_q;

  assign tick = en && (div_q == presc);

  always_ff @(posedge CLKEXT or negedge RST_N) begin
    if (!RST_N)    div_q <= '0;
    else if (clr)  div_q <= '0;
    else if (en)   div_q <= tick ? '0 : div_q + 1'b1;
  end

endmodule
`endif

// File: rtl/ctr_sequencer.sv
// Load/run/terminate controller for the NPU 16-bit down-counter.
// Optional tick prescaler enabled by defining NPU_CTR_PRESCALE_EN.
module ctr_sequencer
  import ctr_pkg::*;
#(
`ifdef NPU_CTR_PRESCALE_EN
  parameter int PRESC_W = 4,
`endif
  parameter logic [CNT_W-1:0] RELOAD_RST = RELOAD_RST_DEF
) (
  input  logic             CLKEXT,
  input  logic             RST_N,
  input  logic [7:0]       DB,
  input  logic [7:0]       DD,
  input  logic             LD_HI,
  input  logic             LD_LO,
  input  logic             START,
  input  logic             STOP,
  input  logic             MODE,
  input  logic             IRQ_CLR,
`ifdef NPU_CTR_PRESCALE_EN
  input  logic [PRESC_W-1:0] PRESC,
`endif
  output logic             CTR_OUT,
  output logic             IRQ,
  output logic             BUSY,
  output logic [CNT_W-1:0] CNT,
  output logic [1:0]       STATE
);

  ctr_state_t       state_q, state_d;
  logic [CNT_W-1:0] reload_q, cnt_d;
  logic             mode_q, mode_d;
  logic             tick, term;

  always_ff @(posedge CLKEXT or negedge RST_N) begin
    if (!RST_N) begin
      reload_q <= RELOAD_RST;
    end else begin
      if (LD_HI) reload_q[15:8] <= DB;
      if (LD_LO) reload_q[7:0]  <= DD;
    end
  end

`ifdef NPU_CTR_PRESCALE_EN
  // Restart the divider on load and on every auto-reload so each period is whole.
  logic presc_clr;
  assign presc_clr = (state_q == ST_LOAD) || (term && mode_q);

  ctr_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .CLKEXT (CLKEXT),
    .RST_N  (RST_N),
    .clr    (presc_clr),
    .en     (state_q == ST_RUN),
    .presc  (PRESC),
    .tick   (tick)
  );
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = CNT;
    mode_d  = mode_q;
    term    = 1'b0;
    if (STOP) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: if (START && reload_q != '0) state_d = ST_LOAD;
        ST_LOAD: begin
          cnt_d   = reload_q;
          mode_d  = MODE;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          // A zero count (reload cleared mid-flight) saturates rather than wrapping.
          if (tick && CNT != '0) begin
            if (CNT == CNT_W'(1)) begin
              term = 1'b1;
              if (mode_q) begin
                cnt_d = reload_q;
              end else begin
                cnt_d   = '0;
                state_d = ST_DONE;
              end
            end else begin
              cnt_d = CNT - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLKEXT or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      CNT     <= '0;
      mode_q  <= 1'b0;
      CTR_OUT <= 1'b0;
      IRQ     <= 1'b0;
    end else begin
      state_q <= state_d;
      CNT     <= cnt_d;
      mode_q  <= mode_d;
      CTR_OUT <= term;
      IRQ     <= term || (IRQ && !IRQ_CLR);
    end
  end

  assign BUSY  = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign STATE = state_q;

endmodule

// File: tb/tb_ctr_sequencer.sv
// Directed bench for ctr_sequencer (default build, no prescaler).
module tb_ctr_sequencer;

  logic        CLKEXT = 1'b0;
  logic        RST_N;
  logic [7:0]  DB, DD;
  logic        LD_HI, LD_LO, START, STOP, MODE, IRQ_CLR;
  logic        CTR_OUT, IRQ, BUSY;
  logic [15:0] CNT;
  logic [1:0]  STATE;

  int nvec = 0;
  int nerr = 0;

  ctr_sequencer dut (
    .CLKEXT  (CLKEXT),
    .RST_N   (RST_N),
    .DB      (DB),
    .DD      (DD),
    .LD_HI   (LD_HI),
    .LD_LO   (LD_LO),
    .START   (START),
    .STOP    (STOP),
    .MODE    (MODE),
    .IRQ_CLR (IRQ_CLR),
    .CTR_OUT (CTR_OUT),
    .IRQ     (IRQ),
    .BUSY    (BUSY),
    .CNT     (CNT),
    .STATE   (STATE)
  );

  always #5 CLKEXT = ~CLKEXT;

  task automatic cyc();
    @(posedge CLKEXT);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    assert (obs === exp)
      else begin
        nerr++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // Per-cycle check of count, pulse and state in one call.
  task automatic chk3(input string tag, input logic [15:0] c, input logic p, input logic [1:0] s);
    chk({tag, ".cnt"}, CNT, c);
    chk({tag, ".pulse"}, {15'd0, CTR_OUT}, {15'd0, p});
    chk({tag, ".state"}, {14'd0, STATE}, {14'd0, s});
  endtask

  task automatic wr_reload(input logic [7:0] hi, input logic [7:0] lo);
    DB = hi; DD = lo; LD_HI = 1'b1; LD_LO = 1'b1;
    cyc();
    LD_HI = 1'b0; LD_LO = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; DB = '0; DD = '0; LD_HI = 0; LD_LO = 0;
    START = 0; STOP = 0; MODE = 0; IRQ_CLR = 0;
    cyc(); cyc();
    chk3("rst", 16'h0000, 1'b0, 2'b00);
    chk("rst.irq", {15'd0, IRQ}, 16'd0);
    chk("rst.busy", {15'd0, BUSY}, 16'd0);
    RST_N = 1'b1;
    cyc();

    // Reset while running from 0x1234
    wr_reload(8'h12, 8'h34);
    START = 1; cyc(); START = 0;
    chk3("t1.load", 16'h0000, 1'b0, 2'b01);
    chk("t1.busy", {15'd0, BUSY}, 16'd1);
    cyc(); chk3("t1.run0", 16'h1234, 1'b0, 2'b10);
    cyc(); chk3("t1.run1", 16'h1233, 1'b0, 2'b10);
    #2 RST_N = 1'b0; #1;
    chk3("t1.async", 16'h0000, 1'b0, 2'b00);
    chk("t1.irq", {15'd0, IRQ}, 16'd0);
    chk("t1.busy0", {15'd0, BUSY}, 16'd0);
    RST_N = 1'b1;
    cyc();
    START = 1; cyc(); START = 0;
    cyc(); chk3("t1.rldrst", 16'hFFFF, 1'b0, 2'b10);
    STOP = 1; cyc(); STOP = 0;
    chk3("t1.stop", 16'hFFFF, 1'b0, 2'b00);

    // One-shot, reload 5
    wr_reload(8'h00, 8'h05);
    MODE = 0; START = 1; cyc(); START = 0;
    cyc(); chk3("t2.e1", 16'd5, 1'b0, 2'b10);
    cyc(); chk3("t2.e2", 16'd4, 1'b0, 2'b10);
    cyc(); chk3("t2.e3", 16'd3, 1'b0, 2'b10);
    cyc(); chk3("t2.e4", 16'd2, 1'b0, 2'b10);
    cyc(); chk3("t2.e5", 16'd1, 1'b0, 2'b10);
    cyc(); chk3("t2.e6", 16'd0, 1'b1, 2'b11);
    chk("t2.irq", {15'd0, IRQ}, 16'd1);
    chk("t2.busy", {15'd0, BUSY}, 16'd0);
    cyc(); chk3("t2.e7", 16'd0, 1'b0, 2'b11);
    IRQ_CLR = 1; cyc(); IRQ_CLR = 0;
    chk("t2.irqclr", {15'd0, IRQ}, 16'd0);

    // START and STOP together in DONE -> IDLE
    START = 1; STOP = 1; cyc(); START = 0; STOP = 0;
    chk3("t4.startstop", 16'd0, 1'b0, 2'b00);
    // Zero reload: START ignored
    wr_reload(8'h00, 8'h00);
    START = 1; cyc(); START = 0;
    chk3("t4.zero0", 16'd0, 1'b0, 2'b00);
    cyc(); chk3("t4.zero1", 16'd0, 1'b0, 2'b00);

    // Auto-reload 3, reload changed to 2 mid-period; IRQ clear interplay
    wr_reload(8'h00, 8'h03);
    MODE = 1; START = 1; cyc(); START = 0;
    cyc(); MODE = 0;
    chk3("t3.e1", 16'd3, 1'b0, 2'b10);
    cyc(); chk3("t3.e2", 16'd2, 1'b0, 2'b10);
    cyc(); chk3("t3.e3", 16'd1, 1'b0, 2'b10);
    cyc(); chk3("t3.e4", 16'd3, 1'b1, 2'b10);
    chk("t3.irq4", {15'd0, IRQ}, 16'd1);
    IRQ_CLR = 1; cyc(); IRQ_CLR = 0;
    chk3("t3.e5", 16'd2, 1'b0, 2'b10);
    chk("t3.irq5", {15'd0, IRQ}, 16'd0);
    cyc(); chk3("t3.e6", 16'd1, 1'b0, 2'b10);
    IRQ_CLR = 1; cyc();
    chk3("t3.e7", 16'd3, 1'b1, 2'b10);
    chk("t5.setwins", {15'd0, IRQ}, 16'd1);
    DD = 8'h02; LD_LO = 1; cyc(); LD_LO = 0; IRQ_CLR = 0;
    chk3("t3.e8", 16'd2, 1'b0, 2'b10);
    chk("t5.clr", {15'd0, IRQ}, 16'd0);
    cyc(); chk3("t3.e9", 16'd1, 1'b0, 2'b10);
    cyc(); chk3("t3.e10", 16'd2, 1'b1, 2'b10);
    cyc(); chk3("t3.e11", 16'd1, 1'b0, 2'b10);
    cyc(); chk3("t3.e12", 16'd2, 1'b1, 2'b10);
    STOP = 1; cyc(); STOP = 0;
    chk3("t3.stop", 16'd2, 1'b0, 2'b00);
    cyc(); chk3("t3.frozen", 16'd2, 1'b0, 2'b00);

    // Auto-reload with reload 1: back-to-back pulses
    wr_reload(8'h00, 8'h01);
    MODE = 1; START = 1; cyc(); START = 0;
    cyc(); chk3("r1.load", 16'd1, 1'b0, 2'b10);
    cyc(); chk3("r1.p0", 16'd1, 1'b1, 2'b10);
    cyc(); chk3("r1.p1", 16'd1, 1'b1, 2'b10);
    STOP = 1; cyc(); STOP = 0;
    chk3("r1.stop", 16'd1, 1'b0, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
